// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle radix-2 shift-add sequencer for the RV32M
// multiply group (MUL, MULH, MULHSU, MULHU).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   kill                pipeline flush, aborts any in-flight operation
//   req_valid/req_ready request handshake (ready only in IDLE, kill=0)
//   req_op              00=MUL 01=MULH 10=MULHSU 11=MULHU
//   req_a, req_b        rs1 / rs2 operands
//   req_tag             opaque tag returned on resp_tag
//   resp_valid/ready    response handshake
//   resp_result         selected product word (low for MUL, high otherwise)
//   resp_tag            tag of the completed request
//   busy                high in any state other than IDLE
module mul_seq_ctrl #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int ZERO_SKIP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [1:0]        state;
  logic [1:0]        op;
  logic [TAG_W-1:0]  tag;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic              neg;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              a_signed;
  logic              b_signed;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              zero_op;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod_fix;
  logic              accept;

  assign req_ready  = (state == S_IDLE) && !kill;
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign accept     = req_valid && req_ready;

  // Operand signedness: a is signed for MULH/MULHSU, b only for MULH.
  // Negating -2^(XLEN-1) wraps to 2^(XLEN-1), which is the correct
  // unsigned magnitude.
  always_comb begin
    a_signed = (req_op == 2'b01) || (req_op == 2'b10);
    b_signed = (req_op == 2'b01);
    sign_a   = a_signed && req_a[XLEN-1];
    sign_b   = b_signed && req_b[XLEN-1];
    mag_a    = sign_a ? (~req_a + 1'b1) : req_a;
    mag_b    = sign_b ? (~req_b + 1'b1) : req_b;
    zero_op  = (req_a == '0) || (req_b == '0);
  end

  // Single shared XLEN-bit adder: upper accumulator half plus the gated
  // multiplicand, with the carry kept as the top bit.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (mplier[0] ? mcand : '0)};
    prod_fix = neg ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op          <= '0;
      tag         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      neg         <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      resp_result <= '0;
      resp_tag    <= '0;
    end else if (kill) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op     <= req_op;
            tag    <= req_tag;
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= sign_a ^ sign_b;
            acc    <= '0;
            cnt    <= '0;
            if ((ZERO_SKIP != 0) && zero_op) begin
              resp_result <= '0;
              resp_tag    <= req_tag;
              state       <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // {carry, sum, low half} shifted right by one.
          acc    <= {sum, acc[XLEN-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          resp_result <= (op == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          resp_tag    <= tag;
          state       <= S_DONE;
        end
        default: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        kill;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_tag;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;
  int   n;

  mul_seq_ctrl #(.XLEN(32), .TAG_W(5), .ZERO_SKIP(1)) dut (
    .clk(clk), .rst(rst), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from wide sign/zero-extended multiplication.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Drive a request at a falling edge, wait for acceptance, push the
  // expected response. Returns #1 after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input logic [31:0] exp);
    exp_t e;
    int   w;
    @(negedge clk);
    req_valid = 1'b1; req_op = o; req_a = a; req_b = b; req_tag = t;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scramble inputs: must have no effect after acceptance.
    req_op = ~o; req_a = ~a; req_b = $urandom; req_tag = ~t;
    e.res = exp; e.tag = t;
    q.push_back(e);
  endtask

  // Count edges after acceptance until resp_valid, then compare to the
  // scoreboard head and complete the handshake.
  task automatic recv(input string name, input int lat);
    exp_t e;
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, lat);
    if (q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check({name, "_result"}, resp_result, e.res);
      check({name, "_tag"}, {27'b0, resp_tag}, {27'b0, e.tag});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({name, "_valid_drop"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] hold_r;
    logic [4:0]  hold_t;
    tests = 0; fails = 0;
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", resp_result, 32'd0);
    check("rst_tag", {27'b0, resp_tag}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
    recv("mulhu_ff", 33);
    send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001);
    recv("mul_ff", 33);
    send(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
    recv("mulh_minmin", 33);
    send(2'b01, 32'h8000_0000, 32'h0000_0001, 5'd4, 32'hFFFF_FFFF);
    recv("mulh_min1", 33);
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF);
    recv("mulhsu_m1", 33);
    send(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd22, 32'hFFFF_FFEB);
    recv("mul_7m3", 33);

    // Zero skip with stalled consumer.
    send(2'b00, 32'd0, 32'h1234_5678, 5'd11, 32'd0);
    check("zs_valid", {31'b0, resp_valid}, 32'd1);
    hold_r = resp_result; hold_t = resp_tag;
    check("zs_tag_now", {27'b0, hold_t}, 32'd11);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("zs_hold_result", resp_result, hold_r);
      check("zs_hold_tag", {27'b0, resp_tag}, {27'b0, hold_t});
      check("zs_hold_ready", {31'b0, req_ready}, 32'd0);
      check("zs_hold_valid", {31'b0, resp_valid}, 32'd1);
    end
    recv("zero_skip", 0);

    // Kill at CALC iteration 10.
    send(2'b11, 32'hDEAD_BEEF, 32'hBEEF_CAFE, 5'd7, 32'd0);
    q.delete();
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    check("kill_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    check("kill_valid", {31'b0, resp_valid}, 32'd0);
    send(2'b11, 32'd3, 32'd5, 5'd9, 32'd0);
    recv("after_kill", 33);

    // Reset mid-operation.
    send(2'b11, 32'hDEAD_BEEF, 32'hBEEF_CAFE, 5'd8, 32'd0);
    q.delete();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_valid", {31'b0, resp_valid}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_result", resp_result, 32'd0);
    check("mrst_tag", {27'b0, resp_tag}, 32'd0);
    check("mrst_ready", {31'b0, req_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("mrst_no_resp", {31'b0, resp_valid}, 32'd0);

    // Back-to-back: handshake cycle N with a pending request.
    send(2'b00, 32'd1234, 32'd5678, 5'd12, 32'd7006652);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_first_latency", n, 33);
    check("b2b_first_result", resp_result, 32'd7006652);
    void'(q.pop_front());
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'hFFFF_FFFE; req_b = 32'd3; req_tag = 5'd13;
    check("b2b_ready_N", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("b2b_ready_N1", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    q.push_back('{res: 32'hFFFF_FFFF, tag: 5'd13});
    recv("b2b_second", 33);

    // A few random operations against the wide-multiply model.
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      send(ro, ra, rb, 5'(i + 16), model(ro, ra, rb));
      recv("random", 33);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
